// File: rtl/adder_sum_accumulator.sv
// Frame accumulator behind the 2-input adder: sums COUNT {carry, result} samples per frame
// and presents the total on a valid/ready port. A flush closes a partial frame early.
module adder_sum_accumulator #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4,
    localparam int ACC_WIDTH = WIDTH + 1 + $clog2(COUNT + 1),
    localparam int CNT_WIDTH = $clog2(COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_result,
    input  logic                 in_carry,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_partial
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] COUNT_C = CNT_WIDTH'(COUNT);

    state_t                 r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [ACC_WIDTH-1:0]   r_sum;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_partial;

    state_t                 w_state_next;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic [ACC_WIDTH-1:0]   w_sum_next;
    logic [CNT_WIDTH-1:0]   w_count_next;
    logic                   w_partial_next;

    logic                   w_accept;
    logic [ACC_WIDTH-1:0]   w_sample;
    logic [ACC_WIDTH-1:0]   w_acc_sum;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;

    // Input side is closed during reset and while a finished frame waits downstream.
    assign in_ready  = rst_n && (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign out_sum     = r_sum;
    assign out_count   = r_count;
    assign out_partial = r_partial;

    assign w_accept  = in_valid && in_ready;
    assign w_sample  = w_accept ? ACC_WIDTH'({in_carry, in_result}) : '0;
    assign w_acc_sum = r_acc + w_sample;
    assign w_cnt_inc = r_cnt + CNT_WIDTH'(w_accept);

    always_comb begin
        w_state_next   = r_state;
        w_acc_next     = r_acc;
        w_cnt_next     = r_cnt;
        w_sum_next     = r_sum;
        w_count_next   = r_count;
        w_partial_next = r_partial;
        case (r_state)
            ST_ACCUM: begin
                w_acc_next = w_acc_sum;
                w_cnt_next = w_cnt_inc;
                if (w_accept && (w_cnt_inc == COUNT_C)) begin
                    w_state_next   = ST_DONE;
                    w_sum_next     = w_acc_sum;
                    w_count_next   = COUNT_C;
                    w_partial_next = 1'b0;
                end else if (flush && (w_cnt_inc != '0)) begin
                    // A sample arriving with the flush is folded into the closing frame.
                    w_state_next   = ST_DONE;
                    w_sum_next     = w_acc_sum;
                    w_count_next   = w_cnt_inc;
                    w_partial_next = (w_cnt_inc < COUNT_C);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_ACCUM;
                    w_acc_next   = '0;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_count   <= '0;
            r_partial <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_acc     <= w_acc_next;
            r_cnt     <= w_cnt_next;
            r_sum     <= w_sum_next;
            r_count   <= w_count_next;
            r_partial <= w_partial_next;
        end
    end

endmodule
